// File: rtl/mem_cycle_arbiter_pkg.sv
// mem_cycle_arbiter_pkg: shared widths, major-state and memory-arbiter state codes
package mem_cycle_arbiter_pkg;
    localparam int AW = 15;
    localparam int DW = 12;
    typedef enum logic [1:0] {MAJ_F0, MAJ_D0, MAJ_E0, MAJ_BRK} major_state_t;
    typedef enum logic [2:0] {ARB_IDLE, ARB_ADDR, ARB_READ, ARB_WRITE, ARB_DONE} arb_state_t;
endpackage

// File: rtl/mem_cycle_arbiter_brk_prio_enc.sv
// brk_prio_enc: lowest-index-wins priority encoder over the break request lines
module brk_prio_enc #(
    parameter int NCH = 4,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    output logic           valid,
    output logic [IW-1:0]  idx
);
    // scan from the top so the lowest requesting index is the last one written
    always_comb begin
        valid = |req;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
    end
endmodule

// File: rtl/mem_cycle_arbiter.sv
// mem_cycle_arbiter: shares main memory between the CPU and data-break channels, one 4-clock cycle per access
module mem_cycle_arbiter
    import mem_cycle_arbiter_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int MAXBRK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [AW-1:0]     cpu_addr,
    input  logic              cpu_we,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_done,
    output logic              cpu_hold,
    input  logic [NCH-1:0]    brk_req,
    input  logic [NCH*AW-1:0] brk_addr,
    input  logic [NCH-1:0]    brk_we,
    input  logic [NCH-1:0]    brk_inc,
    input  logic [NCH*DW-1:0] brk_wdata,
    output logic [NCH-1:0]    brk_done,
    output logic [DW-1:0]     rdata,
    output logic              ovf,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RW = $clog2(MAXBRK + 1);

    arb_state_t state, state_nxt;
    logic brk_v, arb_ok, cpu_win, grant, own_cpu, lat_we, lat_inc;
    logic [IW-1:0] brk_idx, own_idx;
    logic [RW-1:0] brk_run;
    logic [DW-1:0] lat_wdata, data;

    brk_prio_enc #(.NCH(NCH), .IW(IW)) u_prio (
        .req   (brk_req),
        .valid (brk_v),
        .idx   (brk_idx)
    );

    assign cpu_hold = cpu_req & ~cpu_done;
    assign arb_ok   = (state == ARB_IDLE) || (state == ARB_DONE);
    assign cpu_win  = cpu_req & (~brk_v | (brk_run == RW'(MAXBRK)));
    assign grant    = arb_ok & (cpu_win | brk_v);

    // next state: arbitrate in IDLE/DONE, otherwise walk the fixed memory sequence
    always_comb begin
        state_nxt = ARB_IDLE;
        state_nxt = arb_ok ? (grant ? ARB_ADDR : ARB_IDLE) :
                    (state == ARB_ADDR) ? ARB_READ :
                    (state == ARB_READ) ? ARB_WRITE : ARB_DONE;
    end

    // state register, winner latch, break-run counter and registered memory/result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            brk_run   <= '0;
            own_cpu   <= 1'b0;
            own_idx   <= '0;
            lat_we    <= 1'b0;
            lat_inc   <= 1'b0;
            lat_wdata <= '0;
            data      <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            cpu_done  <= 1'b0;
            brk_done  <= '0;
            rdata     <= '0;
            ovf       <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_we   <= (state == ARB_READ) & (lat_we | lat_inc);
            cpu_done <= (state == ARB_WRITE) & own_cpu;
            brk_done <= ((state == ARB_WRITE) & ~own_cpu) ? NCH'(1) << own_idx : '0;
            if (grant) begin
                own_cpu   <= cpu_win;
                own_idx   <= brk_idx;
                mem_addr  <= cpu_win ? cpu_addr : brk_addr[AW*int'(brk_idx) +: AW];
                lat_we    <= cpu_win ? cpu_we : brk_we[brk_idx];
                lat_inc   <= ~cpu_win & brk_inc[brk_idx];
                lat_wdata <= cpu_win ? cpu_wdata : brk_wdata[DW*int'(brk_idx) +: DW];
                brk_run   <= cpu_win ? '0 : (brk_run == RW'(MAXBRK)) ? brk_run : brk_run + RW'(1);
            end else if (arb_ok) begin
                brk_run <= '0;
            end
            if (state == ARB_READ) begin
                data      <= mem_rdata;
                mem_wdata <= lat_inc ? mem_rdata + DW'(1) : lat_wdata;
            end
            if (state == ARB_WRITE) begin
                rdata <= lat_inc ? data + DW'(1) : data;
                ovf   <= lat_inc & (data == 12'o7777);
            end
        end
    end
endmodule

// File: tb/tb_mem_cycle_arbiter.sv
// tb_mem_cycle_arbiter: directed checks of memory sequencing, priority, increment and reset behaviour
module tb_mem_cycle_arbiter;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [14:0]       cpu_addr;
    logic [11:0]       cpu_wdata;
    logic              cpu_done, cpu_hold;
    logic [NCH-1:0]    brk_req, brk_we, brk_inc, brk_done;
    logic [NCH*15-1:0] brk_addr;
    logic [NCH*12-1:0] brk_wdata;
    logic [11:0]       rdata, mem_wdata, mem_rdata;
    logic              ovf, mem_we;
    logic [14:0]       mem_addr;
    logic [11:0]       mem [0:32767];
    int checks = 0;
    int errors = 0;

    mem_cycle_arbiter #(.NCH(NCH), .MAXBRK(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_hold(cpu_hold),
        .brk_req(brk_req), .brk_addr(brk_addr), .brk_we(brk_we), .brk_inc(brk_inc),
        .brk_wdata(brk_wdata), .brk_done(brk_done),
        .rdata(rdata), .ovf(ovf),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous-read memory model: data appears the clock after the address
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        brk_req = '0; brk_we = '0; brk_inc = '0; brk_addr = '0; brk_wdata = '0;
    endtask

    task automatic preload(input logic [14:0] a, input logic [11:0] v);
        mem[a] <= v;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL reset_cpu_done got %b want 0", cpu_done); end
        checks++; if (brk_done !== 4'b0) begin errors++; $display("FAIL reset_brk_done got %b want 0000", brk_done); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (rdata !== 12'o0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_rdata_ovf got %o/%b want 0000/0", rdata, ovf); end
        checks++; if (mem_addr !== 15'o0 || mem_wdata !== 12'o0) begin errors++; $display("FAIL reset_mem_bus got %o/%o want 0/0", mem_addr, mem_wdata); end
        cpu_req = 1; #1;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL hold_comb got %b want 1", cpu_hold); end
        cpu_req = 0; #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", cpu_hold); end
        @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        int done_at = 0;
        int we_seen = 0;
        logic [11:0] rd = '0;
        preload(15'o10200, 12'o4321);
        cpu_req = 1; cpu_we = 0; cpu_addr = 15'o10200;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
            if (k == 1) begin
                checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rd_hold got %b want 1", cpu_hold); end
            end
            if (k == 2) begin
                checks++; if (mem_addr !== 15'o10200) begin errors++; $display("FAIL rd_addr got %o want 10200", mem_addr); end
            end
            if (cpu_done && done_at == 0) begin done_at = k; rd = rdata; cpu_req = 0; end
        end
        checks++; if (done_at != 4) begin errors++; $display("FAIL rd_latency got %0d want 4", done_at); end
        checks++; if (rd !== 12'o4321) begin errors++; $display("FAIL rd_data got %o want 4321", rd); end
        checks++; if (we_seen != 0) begin errors++; $display("FAIL rd_no_write got %0d want 0", we_seen); end
        clear_inputs();
    endtask

    task automatic test_brk_inc();
        int done_at = 0;
        logic [11:0] wd = 12'o1111;
        logic [3:0] bd = '0;
        logic [11:0] rd = 12'o1111;
        logic of = 0;
        preload(15'o00030, 12'o7777);
        brk_req[1] = 1; brk_inc[1] = 1; brk_we[1] = 0; brk_addr[15 +: 15] = 15'o00030;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) wd = mem_wdata;
            if (brk_done != 0 && done_at == 0) begin done_at = k; bd = brk_done; rd = rdata; of = ovf; brk_req = '0; end
        end
        checks++; if (wd !== 12'o0000) begin errors++; $display("FAIL inc_wdata got %o want 0000", wd); end
        checks++; if (done_at != 4 || bd !== 4'b0010) begin errors++; $display("FAIL inc_done got %0d/%b want 4/0010", done_at, bd); end
        checks++; if (rd !== 12'o0000 || of !== 1'b1) begin errors++; $display("FAIL inc_result got %o/%b want 0000/1", rd, of); end
        checks++; if (mem[15'o00030] !== 12'o0000) begin errors++; $display("FAIL inc_mem got %o want 0000", mem[15'o00030]); end
        clear_inputs();
    endtask

    task automatic test_cpu_write();
        int we_cnt = 0;
        int we_at = 0;
        logic [11:0] rd = '0;
        preload(15'o00100, 12'o1234);
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'o00100; cpu_wdata = 12'o5555;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) begin we_cnt++; we_at = k; end
            if (cpu_done) begin rd = rdata; cpu_req = 0; end
        end
        checks++; if (we_cnt != 1 || we_at != 3) begin errors++; $display("FAIL wr_strobe got %0d@%0d want 1@3", we_cnt, we_at); end
        checks++; if (rd !== 12'o1234) begin errors++; $display("FAIL wr_old_data got %o want 1234", rd); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wr_ovf got %b want 0", ovf); end
        checks++; if (mem[15'o00100] !== 12'o5555) begin errors++; $display("FAIL wr_mem got %o want 5555", mem[15'o00100]); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int got [6];
        int want [6] = '{0, 0, 8, 0, 0, 8};
        int n = 0;
        int hold_bad = 0;
        for (int i = 0; i < 6; i++) got[i] = -1;
        brk_req = 4'b0101; brk_addr[0 +: 15] = 15'o00200; brk_addr[30 +: 15] = 15'o00300;
        cpu_req = 1; cpu_addr = 15'o00400;
        for (int k = 1; k <= 30 && n < 6; k++) begin
            @(negedge clk);
            if (cpu_hold !== ~cpu_done) hold_bad++;
            if (cpu_done) begin got[n] = 8; n++; end
            else if (brk_done != 0) begin got[n] = (brk_done == 4'b0001) ? 0 : (brk_done == 4'b0100) ? 2 : 9; n++; end
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] != want[i]) begin errors++; $display("FAIL grant_order[%0d] got %0d want %0d", i, got[i], want[i]); end
        end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL b2b_hold got %0d bad cycles want 0", hold_bad); end
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_cycle();
        int bad = 0;
        preload(15'o07000, 12'o2222);
        brk_req[3] = 1; brk_we[3] = 1; brk_addr[45 +: 15] = 15'o07000; brk_wdata[36 +: 12] = 12'o0666;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || mem_addr !== 15'o0) begin errors++; $display("FAIL rst_mid_state got we=%b addr=%o want 0/0", mem_we, mem_addr); end
        clear_inputs();
        reset = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_we || brk_done != 0 || cpu_done) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", bad); end
        checks++; if (mem[15'o07000] !== 12'o2222) begin errors++; $display("FAIL rst_mid_mem got %o want 2222", mem[15'o07000]); end
    endtask

    task automatic test_withdraw();
        int done_at = 0;
        int after = 0;
        logic [11:0] rd = '0;
        preload(15'o00040, 12'o3333);
        brk_req[0] = 1; brk_addr[0 +: 15] = 15'o00040;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) brk_req = '0;
            if (brk_done == 4'b0001 && done_at == 0) begin done_at = k; rd = rdata; end
            else if (k > 4 && (brk_done != 0 || mem_addr != 15'o00040)) after++;
        end
        checks++; if (done_at != 4) begin errors++; $display("FAIL wd_done got %0d want 4", done_at); end
        checks++; if (rd !== 12'o3333) begin errors++; $display("FAIL wd_data got %o want 3333", rd); end
        checks++; if (after != 0) begin errors++; $display("FAIL wd_idle got %0d stray cycles want 0", after); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_cpu_read();
        test_brk_inc();
        test_cpu_write();
        test_back_to_back();
        test_reset_mid_cycle();
        test_withdraw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_cycle_arbiter.md
# mem_cycle_arbiter

Shares the single 32K×12 main memory between the CPU major-state sequencer and up to NCH data-break (DMA) channels. It supports read, write and three-cycle-break increment (read-modify-write +1) accesses. It arbitrates once per memory cycle and runs a fixed 4-clock memory sequence. It stalls the CPU sequencer through `cpu_hold` while a break channel owns memory.

## Interface
- NCH, 4 — number of data-break channels (1..8)
- MAXBRK, 2 — max consecutive break cycles before a pending CPU request wins (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU memory request; held until `cpu_done`
- cpu_addr  in  15  {field[0:2], addr[0:11]}
- cpu_we  in  1  write request
- cpu_wdata  in  12  write data
- cpu_done  out  1  one-clock completion pulse
- cpu_hold  out  1  `cpu_req & ~cpu_done`; CPU sequencer waits in F0/D0/E0 while high
- brk_req  in  NCH  per-channel request; held until matching `brk_done` bit
- brk_addr  in  NCH×15  per-channel address, channel i at [15i+14:15i]
- brk_we  in  NCH  write
- brk_inc  in  NCH  increment access; overrides `brk_we`
- brk_wdata  in  NCH×12  per-channel write data
- brk_done  out  NCH  one-hot, one-clock completion pulse
- rdata  out  12  access result, valid while any done bit is high
- ovf  out  1  increment wrapped 7777→0000, valid with done
- mem_addr  out  15  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  12  memory write data
- mem_rdata  in  12  memory read data, valid the clock after `mem_addr` is presented

## Operation
- States: IDLE, ADDR, READ, WRITE, DONE.
- **Arbitration** happens in IDLE and DONE only:
  - The lowest-index requesting break channel wins over the CPU.
  - Exception: if `brk_run == MAXBRK` and `cpu_req` is high, the CPU wins.
- **Winner latch:** on a win, latch owner, addr, we, inc and wdata, then go to ADDR. With no request, IDLE stays IDLE and DONE goes to IDLE.
- **brk_run** counter:
  - +1 on each break grant, saturating at MAXBRK.
  - Cleared on a CPU grant.
  - Cleared when entering IDLE with no winner.
- **ADDR:** drive the latched `mem_addr`.
- **READ:** capture `mem_rdata` into the data register.
- **WRITE:** `mem_we` = latched we | inc.
  - Write data is wdata, or data+1 for inc (12-bit wrap).
  - `ovf` = (data == 7777) & inc.
- **DONE:** pulse the owner's done bit.
  - `rdata` = the pre-write memory contents for read and write accesses.
  - `rdata` = the incremented value for inc accesses.
- Data on `rdata` is a core-style read-restore result: a write always returns the old word.
- **Request withdrawal:**
  - A request dropped before grant is withdrawn with no side effect.
  - A request dropped after grant does not abort; the cycle completes and done pulses regardless.
- **Simultaneous CPU and channel requests:** priority rule above; all requests are sampled in the same clock.
- **Reset mid-cycle:** the state returns to IDLE on that edge, so a write in progress is aborted before WRITE.

## Timing
- Request seen in IDLE at T: ADDR at T+1, READ at T+2, WRITE at T+3, DONE/done pulse at T+4.
- Back-to-back throughput is one access per 4 clocks, with DONE going directly to ADDR.
- `mem_addr` is held stable from ADDR through DONE.
- `mem_we` is high only in WRITE, for exactly one clock.
- `cpu_hold` is combinational, with zero-cycle response to `cpu_req`.
- All other outputs are registered.
- Reset values: state IDLE, `brk_run` 0, and `mem_we`, `cpu_done`, `brk_done`, `ovf`, `rdata`, `mem_addr`, `mem_wdata` all 0.

## Structure
- State encodings for the arbiter go in the shared parameters include alongside the major-state codes:
  - ARB_IDLE, ARB_ADDR, ARB_READ, ARB_WRITE, ARB_DONE.
- Sub-module `brk_prio_enc`: combinational NCH-wide lowest-index priority encoder producing a valid flag and index.

## Test plan
- CPU read, addr 1.0200, mem=4321, no breaks → `cpu_done` at T+4, `rdata` 4321, `mem_we` never high.
- Channel 1 inc at 0.0030 holding 7777 → WRITE writes 0000, `brk_done`=0010, `rdata`=0000, `ovf`=1.
- CPU write 5555 to 0.0100 holding 1234 → memory 5555 afterwards, `rdata`=1234.
- Channels 0 and 2 continuously requesting with MAXBRK=2 and the CPU requesting → grant order ch0, ch0, CPU, ch0, ch0, CPU; ch2 never granted; `cpu_hold` high except during `cpu_done`.
- Reset asserted during READ of a channel-3 write → next clock IDLE, `mem_we` stays 0, target word unchanged, no done pulse.
- Channel 0 drops `brk_req` during ADDR → cycle completes, `brk_done`[0] pulses at T+4, then IDLE.
